// File: rtl/cbrt_pkg.sv
// Shared definitions for the sequential cube-root block: state encoding and
// width helpers used by the interface, the core and the bench.
package cbrt_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SHIFT    = 3'd1;
  localparam logic [2:0] ST_MUL_GO   = 3'd2;
  localparam logic [2:0] ST_MUL_WAIT = 3'd3;
  localparam logic [2:0] ST_FORM     = 3'd4;
  localparam logic [2:0] ST_TEST     = 3'd5;
  localparam logic [2:0] ST_FIN      = 3'd6;

  // Result width; also the number of digit steps.
  function automatic int rw_of(input int w);
    return (w + 2) / 3;
  endfunction

  // Width that holds the shifted trial subtrahend without truncation.
  function automatic int int_w_of(input int w);
    return 3 * rw_of(w) + 2;
  endfunction

endpackage

// File: rtl/cbrt_seq_if.sv
// Request/result bundle of cbrt_seq plus a debug view of the FSM state.
// Handshake: start is sampled on the rising edge only when the core is not
// busy (IDLE or the done cycle); done is a one-cycle pulse and y_o/rem_o
// are valid from that cycle until the next done.
interface cbrt_seq_if #(parameter int W = 8);
  import cbrt_pkg::*;
  localparam int RW = rw_of(W);

  logic          start;
  logic [W-1:0]  x_i;
  logic          busy;
  logic          done;
  logic [RW-1:0] y_o;
  logic [W-1:0]  rem_o;
  logic [2:0]    dbg_state;

  modport master (
    output start, x_i,
    input  busy, done, y_o, rem_o, dbg_state
  );

  modport slave (
    input  start, x_i,
    output busy, done, y_o, rem_o, dbg_state
  );

endinterface

// File: rtl/cbrt_seq_mul.sv
// Unsigned shift-add multiplier. The first partial product is taken on the
// load edge, so p is valid AW cycles after the start pulse (busy low then).
module mul_serial #(
  parameter int AW = 3,
  parameter int BW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    a,
  input  logic [BW-1:0]    b,
  output logic             busy,
  output logic [AW+BW-1:0] p
);

  localparam int PW = AW + BW;
  localparam int CW = $clog2(AW + 1);

  logic [PW-1:0] acc;
  logic [PW-1:0] mcand;
  logic [AW-1:0] mplier;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= a[0] ? PW'(b) : '0;
      mcand  <= PW'(b) << 1;
      mplier <= a >> 1;
      cnt    <= CW'(AW - 1);
    end else if (cnt != '0) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);
  assign p    = acc;

endmodule

// File: rtl/cbrt_seq.sv
// Sequential integer cube root: y = floor(cbrt(x)), rem = x - y^3, one root
// bit per digit step, fixed data-independent latency.
module cbrt_seq
  import cbrt_pkg::*;
#(
  parameter int W = 8
) (
  input logic       clk,
  input logic       rst,
  cbrt_seq_if.slave bus
);

  localparam int RW    = rw_of(W);
  localparam int ITERS = RW;
  localparam int INT_W = int_w_of(W);
  localparam int SW    = $clog2(3 * ITERS + 1);
  localparam int BW    = RW + 1;
  localparam int PW    = RW + BW;

  logic [2:0]       state;
  logic [INT_W-1:0] xr;
  logic [RW-1:0]    y;
  logic [SW-1:0]    s;
  logic [PW-1:0]    p;
  logic [INT_W-1:0] b;
  logic [RW-1:0]    y_o_r;
  logic [W-1:0]     rem_o_r;

  logic             mul_start;
  logic             mul_busy;
  logic [BW-1:0]    mul_b;
  logic [PW-1:0]    mul_p;

  logic             accept;
  logic             ge;
  logic [INT_W-1:0] xr_nx;
  logic [RW-1:0]    y_nx;
  logic [INT_W-1:0] p_ext;
  logic [INT_W-1:0] b_nx;

  assign mul_start = (state == ST_MUL_GO);
  assign mul_b     = {1'b0, y} + BW'(1);

  mul_serial #(
    .AW (RW),
    .BW (BW)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (y),
    .b     (mul_b),
    .busy  (mul_busy),
    .p     (mul_p)
  );

  // The done cycle doubles as IDLE so a held start runs back-to-back.
  always_comb begin
    accept = 1'b0;
    ge     = 1'b0;
    xr_nx  = xr;
    y_nx   = y;
    p_ext  = INT_W'(p);
    b_nx   = '0;
    accept = bus.start && ((state == ST_IDLE) || (state == ST_FIN));
    ge     = (xr >= b);
    if (ge) begin
      xr_nx = xr - b;
      y_nx  = y + RW'(1);
    end
    b_nx = (((p_ext << 1) + p_ext) + INT_W'(1)) << s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      xr      <= '0;
      y       <= '0;
      s       <= '0;
      p       <= '0;
      b       <= '0;
      y_o_r   <= '0;
      rem_o_r <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_FIN: begin
          if (accept) begin
            xr    <= INT_W'(bus.x_i);
            y     <= '0;
            s     <= SW'(3 * ITERS);
            state <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          y     <= y << 1;
          s     <= s - SW'(3);
          state <= ST_MUL_GO;
        end
        ST_MUL_GO: begin
          state <= ST_MUL_WAIT;
        end
        ST_MUL_WAIT: begin
          if (!mul_busy) begin
            p     <= mul_p;
            state <= ST_FORM;
          end
        end
        ST_FORM: begin
          b     <= b_nx;
          state <= ST_TEST;
        end
        ST_TEST: begin
          xr <= xr_nx;
          y  <= y_nx;
          // Results land together with the done cycle so they are valid while done is high.
          if (s == '0) begin
            y_o_r   <= y_nx;
            rem_o_r <= xr_nx[W-1:0];
            state   <= ST_FIN;
          end else begin
            state <= ST_SHIFT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != ST_IDLE) && (state != ST_FIN);
  assign bus.done      = (state == ST_FIN);
  assign bus.y_o       = y_o_r;
  assign bus.rem_o     = rem_o_r;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_cbrt_seq.sv
// Bench for cbrt_seq at W=8 and W=16: accepted starts push reference results
// into queues, negedge monitors pop and compare on every done.
module tb_cbrt_seq;

  localparam int RW8  = (8 + 2) / 3;
  localparam int RW16 = (16 + 2) / 3;
  localparam int L8   = RW8 * (RW8 + 4) + 1;
  localparam int L16  = RW16 * (RW16 + 4) + 1;

  typedef struct {
    longint unsigned y;
    longint unsigned r;
    int              acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8;
  exp_t e16;
  int   last8  = -1;
  int   last16 = -1;
  int   free8  = 0;
  int   free16 = 0;
  int   acc8   = 0;

  cbrt_seq_if #(.W(8))  if8 ();
  cbrt_seq_if #(.W(16)) if16 ();

  cbrt_seq #(.W(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  cbrt_seq #(.W(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic longint unsigned ref_root(input longint unsigned x);
    longint unsigned yy = 0;
    while ((yy + 1) * (yy + 1) * (yy + 1) <= x) yy++;
    return yy;
  endfunction

  function automatic exp_t make_exp(input longint unsigned x, input int c);
    exp_t e;
    e.y   = ref_root(x);
    e.r   = x - e.y * e.y * e.y;
    e.acc = c;
    return e;
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A start seen at an edge is accepted once the previous run has reached its done cycle.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (if8.start && cyc >= free8) begin
        q8.push_back(make_exp(longint'(if8.x_i), cyc));
        last8 = cyc;
        free8 = cyc + L8;
        acc8++;
      end
      if (if16.start && cyc >= free16) begin
        q16.push_back(make_exp(longint'(if16.x_i), cyc));
        last16 = cyc;
        free16 = cyc + L16;
      end
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy8", longint'(if8.busy),
          longint'(last8 >= 0 && cyc >= last8 && cyc <= last8 + L8 - 2));
      if (if8.done) begin
        if (q8.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done8_unexpected: got y=%0d rem=%0d expected no done", if8.y_o, if8.rem_o);
        end else begin
          e8 = q8.pop_front();
          chk("y8", longint'(if8.y_o), e8.y);
          chk("rem8", longint'(if8.rem_o), e8.r);
          chk("lat8", longint'(cyc - e8.acc + 1), longint'(L8));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy16", longint'(if16.busy),
          longint'(last16 >= 0 && cyc >= last16 && cyc <= last16 + L16 - 2));
      if (if16.done) begin
        if (q16.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done16_unexpected: got y=%0d rem=%0d expected no done", if16.y_o, if16.rem_o);
        end else begin
          e16 = q16.pop_front();
          chk("y16", longint'(if16.y_o), e16.y);
          chk("rem16", longint'(if16.rem_o), e16.r);
          chk("lat16", longint'(cyc - e16.acc + 1), longint'(L16));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    q8.delete();
    q16.delete();
    last8  = -1;
    last16 = -1;
    free8  = 0;
    free16 = 0;
    #1;
    chk("rst_busy8", longint'(if8.busy), 0);
    chk("rst_done8", longint'(if8.done), 0);
    chk("rst_y8", longint'(if8.y_o), 0);
    chk("rst_rem8", longint'(if8.rem_o), 0);
    chk("rst_busy16", longint'(if16.busy), 0);
    chk("rst_y16", longint'(if16.y_o), 0);
    chk("rst_rem16", longint'(if16.rem_o), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at a negedge with start low again.
  task automatic run8(input logic [7:0] x);
    int guard = 0;
    while (cyc + 1 < free8 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      checks++;
      failures++;
      $display("FAIL run8_wait: got timeout expected idle");
    end
    if8.start = 1'b1;
    if8.x_i   = x;
    @(negedge clk);
    if8.start = 1'b0;
    if8.x_i   = 8'($urandom);
  endtask

  task automatic run16(input logic [15:0] x);
    int guard = 0;
    while (cyc + 1 < free16 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      checks++;
      failures++;
      $display("FAIL run16_wait: got timeout expected idle");
    end
    if16.start = 1'b1;
    if16.x_i   = x;
    @(negedge clk);
    if16.start = 1'b0;
    if16.x_i   = 16'($urandom);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (!(cyc + 1 >= free8 && q8.size() == 0 && cyc + 1 >= free16 && q16.size() == 0)
           && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: got timeout (q8=%0d q16=%0d) expected drained", q8.size(), q16.size());
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0]  dir8[5]  = '{8'd0, 8'd1, 8'd26, 8'd27, 8'd255};
  logic [15:0] dir16[3] = '{16'd65535, 16'd64000, 16'd63999};

  initial begin
    int base;
    if8.start  = 1'b0;
    if8.x_i    = '0;
    if16.start = 1'b0;
    if16.x_i   = '0;
    do_reset();

    // Directed W=8 and W=16 operands, issued back-to-back.
    foreach (dir8[i]) run8(dir8[i]);
    foreach (dir16[i]) run16(dir16[i]);
    wait_idle();

    // Mid-run start with a different operand is ignored.
    run8(8'd125);
    repeat (5) @(negedge clk);
    if8.start = 1'b1;
    if8.x_i   = 8'd8;
    @(negedge clk);
    if8.start = 1'b0;
    wait_idle();

    // Start held high through the done cycle: second run without a gap.
    base      = acc8;
    if8.start = 1'b1;
    if8.x_i   = 8'd200;
    for (int g = 0; g < 100 && acc8 < base + 1; g++) @(negedge clk);
    if8.x_i = 8'd27;
    for (int g = 0; g < 100 && acc8 < base + 2; g++) @(negedge clk);
    if8.start = 1'b0;
    chk("b2b_accepts", longint'(acc8 - base), 2);
    wait_idle();

    // Reset in the middle of a run, then a fresh operand.
    run8(8'd200);
    repeat (8) @(negedge clk);
    do_reset();
    run8(8'd100);
    wait_idle();

    // Full W=8 sweep plus random W=16 operands.
    for (int v = 0; v < 256; v++) run8(8'(v));
    for (int i = 0; i < 20; i++) run16(16'($urandom_range(0, 65535)));
    wait_idle();

    chk("q8_empty", longint'(q8.size()), 0);
    chk("q16_empty", longint'(q16.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    checks++;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
